// File: rtl/cpu_probe_pkg.sv
// Shared command encodings, control state type and derived-width helpers for the
// CPU probe port.
package cpu_probe_pkg;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_HALT = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_RUN  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  function automatic int unsigned calc_nslice(int unsigned width, int unsigned out_w);
    return (width + out_w - 1) / out_w;
  endfunction

  function automatic int unsigned calc_csw(int unsigned channels);
    return $clog2(channels + 1);
  endfunction

  function automatic int unsigned calc_ssw(int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/cpu_probe_ctrl.sv
// Run/halt/single-step controller: strobe edge detect plus the execution FSM that
// drives the core clock-enable.
module cpu_probe_ctrl
  import cpu_probe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] cmd,
  input  logic       cmd_stb,
  output logic       core_en,
  output logic       halted
);

  state_e state_q, state_d;
  logic   stb_q;
  logic   stb_edge;

  // A held strobe only ever issues a single command.
  assign stb_edge = cmd_stb & ~stb_q;

  always_comb begin
    state_d = state_q;
    if (stb_edge) begin
      unique case (cmd)
        CMD_HALT: state_d = ST_HALT;
        CMD_STEP: state_d = ST_STEP;
        CMD_RUN:  state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end else if (state_q == ST_STEP) begin
      state_d = ST_HALT;
    end
  end

  always_comb begin
    core_en = (state_q == ST_RUN) || (state_q == ST_STEP);
    halted  = (state_q == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= cmd_stb;
    end
  end

endmodule

// File: rtl/cpu_probe_port.sv
// Debug/output port: snapshots core buses, muxes any pin-wide slice onto the pins and
// gates core execution. Define PROBE_CYCLE_COUNTER_EN to add an enabled-cycle counter.
module cpu_probe_port
  import cpu_probe_pkg::*;
#(
  parameter  int unsigned WIDTH    = 32,
  parameter  int unsigned CHANNELS = 4,
  parameter  int unsigned OUT_W    = 16,
  localparam int unsigned NSLICE   = calc_nslice(WIDTH, OUT_W),
  localparam int unsigned CSW      = calc_csw(CHANNELS),
  localparam int unsigned SSW      = calc_ssw(NSLICE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS*WIDTH-1:0]  probe_data,
  input  logic [CHANNELS-1:0]        probe_valid,
  input  logic [1:0]                 cmd,
  input  logic                       cmd_stb,
  input  logic [CSW-1:0]             ch_sel,
  input  logic [SSW-1:0]             slice_sel,
  output logic [OUT_W-1:0]           pin_out,
  output logic                       core_en,
  output logic                       halted
);

  logic [WIDTH-1:0]        snap_q [CHANNELS];
  logic [WIDTH-1:0]        word;
  logic [NSLICE*OUT_W-1:0] padded;
  logic [OUT_W-1:0]        slice;
  logic [OUT_W-1:0]        pin_q;

  cpu_probe_ctrl u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (cmd),
    .cmd_stb (cmd_stb),
    .core_en (core_en),
    .halted  (halted)
  );

  // Snapshots only move while the core is enabled, so they freeze in HALT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CHANNELS); i++) snap_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (probe_valid[i] && core_en) snap_q[i] <= probe_data[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef PROBE_CYCLE_COUNTER_EN
  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (core_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    word = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (ch_sel == CSW'(i)) word = snap_q[i];
    end
`ifdef PROBE_CYCLE_COUNTER_EN
    if (ch_sel == CSW'(CHANNELS)) word = cnt_q;
`endif
    // Zero-pad so a final partial slice reads zero-extended.
    padded            = '0;
    padded[WIDTH-1:0] = word;
    slice             = '0;
    for (int k = 0; k < int'(NSLICE); k++) begin
      if (slice_sel == SSW'(k)) slice = padded[k*OUT_W +: OUT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pin_q <= '0;
    end else begin
      pin_q <= slice;
    end
  end

  assign pin_out = pin_q;

endmodule
